// File: rtl/dbg_cmd_parser_pkg.sv
// Shared definitions for the serial debug command parser: ASCII codes,
// opcode encodings, FSM state encoding and small byte helpers.
package dbg_cmd_parser_pkg;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_SP = 8'h20;

  localparam logic [1:0] OP_PING  = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SEP_A  = 3'd1,
    S_ADDR   = 3'd2,
    S_DATA   = 3'd3,
    S_WAIT_T = 3'd4,
    S_ISSUE  = 3'd5,
    S_FLUSH  = 3'd6
  } state_t;

  // CR and LF both end a line
  function automatic logic is_term(input logic [7:0] b);
    return (b == ASCII_CR) || (b == ASCII_LF);
  endfunction

  // Fold lower-case letters so command letters are case-insensitive
  function automatic logic [7:0] to_upper(input logic [7:0] b);
    return ((b >= 8'h61) && (b <= 8'h7A)) ? (b - 8'd32) : b;
  endfunction

endpackage

// File: rtl/dbg_cmd_parser_if.sv
// Byte-stream input and command output of the debug command parser.
//
// Handshakes: a transfer happens on the rising clock edge where both valid
// and ready are high. The sender holds its payload stable while valid is high
// and ready is low; valid never depends combinationally on ready. This holds
// for vld_rx/rdy_rx (byte in) and cmd_valid/cmd_ready (command out).
// err is a one-cycle pulse with no handshake.
interface dbg_cmd_parser_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [7:0]        d_rx;
  logic              vld_rx;
  logic              rdy_rx;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;
  logic              err;

  // Parser side
  modport slave (
    input  d_rx, vld_rx, cmd_ready,
    output rdy_rx, cmd_valid, cmd_op, cmd_addr, cmd_data, err
  );

  // Environment side: uart_rx feeding bytes plus the executor taking commands
  modport master (
    output d_rx, vld_rx, cmd_ready,
    input  rdy_rx, cmd_valid, cmd_op, cmd_addr, cmd_data, err
  );
endinterface

// File: rtl/dbg_cmd_parser_hex_nib_dec.sv
// Combinational ASCII hex digit decoder: 0-9, A-F, a-f to a 4-bit nibble.
module hex_nib_dec (
  input  logic [7:0] byte_in,
  output logic       is_hex,
  output logic [3:0] nib
);

  // Letters A-F/a-f have low nibble 1..6, so adding 9 gives 10..15
  always_comb begin
    is_hex = 1'b1;
    nib    = 4'd0;
    if ((byte_in >= 8'h30) && (byte_in <= 8'h39)) begin
      nib = byte_in[3:0];
    end else if (((byte_in >= 8'h41) && (byte_in <= 8'h46)) ||
                 ((byte_in >= 8'h61) && (byte_in <= 8'h66))) begin
      nib = byte_in[3:0] + 4'd9;
    end else begin
      is_hex = 1'b0;
    end
  end

endmodule

// File: rtl/dbg_cmd_parser.sv
// Serial debug command parser: consumes ASCII bytes from uart_rx and turns
// "R <addr>", "W <addr> <data>" and "P" lines into one command for the debug
// executor. Malformed lines pulse err and are discarded up to the terminator.
module dbg_cmd_parser
  import dbg_cmd_parser_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  dbg_cmd_parser_if.slave  bus,
  output state_t           dbg_state
);

  localparam int ADDR_DIG = ADDR_W / 4;
  localparam int DATA_DIG = DATA_W / 4;
  localparam int MAX_DIG  = (ADDR_DIG > DATA_DIG) ? ADDR_DIG : DATA_DIG;
  localparam int CNT_W    = $clog2(MAX_DIG) + 1;
  localparam logic [CNT_W-1:0] ADDR_FULL = CNT_W'(ADDR_DIG);
  localparam logic [CNT_W-1:0] DATA_FULL = CNT_W'(DATA_DIG);

  state_t            state_q, state_d;
  logic [1:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              err_q;

  logic              take;
  logic              term;
  logic              is_sp;
  logic [7:0]        ch;
  logic              is_hex;
  logic [3:0]        nib;

  logic              bad;
  logic              ld_cmd;
  logic [1:0]        ld_op;
  logic              shift_addr;
  logic              shift_data;
  logic              clr_cnt;

  assign take  = bus.vld_rx && bus.rdy_rx;
  assign term  = is_term(bus.d_rx);
  assign is_sp = (bus.d_rx == ASCII_SP);
  assign ch    = to_upper(bus.d_rx);

  hex_nib_dec u_hex (
    .byte_in (bus.d_rx),
    .is_hex  (is_hex),
    .nib     (nib)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next state and datapath controls; only a consumed byte moves the parser
  always_comb begin
    state_d    = state_q;
    bad        = 1'b0;
    ld_cmd     = 1'b0;
    ld_op      = OP_PING;
    shift_addr = 1'b0;
    shift_data = 1'b0;
    clr_cnt    = 1'b0;
    if (state_q == S_ISSUE) begin
      if (bus.cmd_ready) state_d = S_IDLE;
    end else if (take) begin
      case (state_q)
        S_IDLE: begin
          if (term) begin
            state_d = S_IDLE;
          end else if (ch == "R") begin
            ld_cmd = 1'b1; ld_op = OP_READ;  state_d = S_SEP_A;
          end else if (ch == "W") begin
            ld_cmd = 1'b1; ld_op = OP_WRITE; state_d = S_SEP_A;
          end else if (ch == "P") begin
            ld_cmd = 1'b1; ld_op = OP_PING;  state_d = S_WAIT_T;
          end else begin
            bad = 1'b1;
          end
        end
        S_SEP_A: begin
          if (is_sp) state_d = S_ADDR;
          else       bad = 1'b1;
        end
        S_ADDR: begin
          if (is_hex && (cnt_q != ADDR_FULL)) begin
            shift_addr = 1'b1;
          end else if (is_sp && (op_q == OP_WRITE) && (cnt_q != '0)) begin
            clr_cnt = 1'b1; state_d = S_DATA;
          end else if (term && (op_q == OP_READ) && (cnt_q != '0)) begin
            state_d = S_ISSUE;
          end else begin
            bad = 1'b1;
          end
        end
        S_DATA: begin
          if (is_hex && (cnt_q != DATA_FULL)) shift_data = 1'b1;
          else if (term && (cnt_q != '0))     state_d = S_ISSUE;
          else                                bad = 1'b1;
        end
        S_WAIT_T: begin
          if (term) state_d = S_ISSUE;
          else      bad = 1'b1;
        end
        S_FLUSH: begin
          if (term) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
      // A terminator that causes the error already ends the line
      if (bad) state_d = term ? S_IDLE : S_FLUSH;
    end
  end

  // Moore outputs decoded from the state register; rdy_rx stays low in reset
  always_comb begin
    bus.rdy_rx    = rst && (state_q != S_ISSUE);
    bus.cmd_valid = (state_q == S_ISSUE);
  end

  // Command fields, digit counter and error pulse; fields freeze in ISSUE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q   <= OP_PING;
      addr_q <= '0;
      data_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= bad;
      if (ld_cmd) begin
        op_q   <= ld_op;
        addr_q <= '0;
        data_q <= '0;
        cnt_q  <= '0;
      end
      if (shift_addr) begin
        addr_q <= {addr_q[ADDR_W-5:0], nib};
        cnt_q  <= cnt_q + CNT_W'(1);
      end
      if (shift_data) begin
        data_q <= {data_q[DATA_W-5:0], nib};
        cnt_q  <= cnt_q + CNT_W'(1);
      end
      if (clr_cnt) cnt_q <= '0;
    end
  end

  assign bus.cmd_op   = op_q;
  assign bus.cmd_addr = addr_q;
  assign bus.cmd_data = data_q;
  assign bus.err      = err_q;
  assign dbg_state    = state_q;

endmodule
